// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the RV32 5-stage pipeline: req/gnt/rvalid data-memory
// handshake, load alignment/extension, pipeline stall, misalign/illegal/timeout flags.
module mem_stage_lsu #(
   parameter int DATAWIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNTW           = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   input  logic                 mem_read_i,
   input  logic                 mem_write_i,
   input  logic [2:0]           funct3_i,
   input  logic [DATAWIDTH-1:0] addr_i,
   input  logic [DATAWIDTH-1:0] store_data_i,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   output logic [DATAWIDTH-1:0] dmem_addr_o,
   output logic [3:0]           dmem_be_o,
   output logic [DATAWIDTH-1:0] dmem_wdata_o,
   input  logic                 dmem_gnt_i,
   input  logic                 dmem_rvalid_i,
   input  logic [DATAWIDTH-1:0] dmem_rdata_i,
   output logic [DATAWIDTH-1:0] load_data_o,
   output logic                 stall_o,
   output logic                 misalign_o,
   output logic                 bus_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNTW-1:0]      cnt_q;
   logic                 we_q;
   logic [3:0]           be_q;
   logic [DATAWIDTH-1:0] addr_q, wdata_q, load_data_q;
   logic [2:0]           funct3_q;
   logic [1:0]           off_q;

   logic                 start, illegal, misaligned, accept, limit, timeout;
   logic [3:0]           be_d;
   logic [DATAWIDTH-1:0] wdata_d, fmt_data;
   logic [7:0]           byte_sel;
   logic [15:0]          half_sel;

   // Request decode, evaluated against the live EX/MEM fields while IDLE.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      start      = rst & valid_i & (mem_read_i | mem_write_i);
      illegal    = 1'b0;
      misaligned = 1'b0;
      if (mem_read_i & mem_write_i)
         illegal = 1'b1;
      else if (mem_read_i)
         illegal = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11);
      else
         illegal = funct3_i[2] | (funct3_i[1:0] == 2'b11);
      case (funct3_i[1:0])
         2'b01:   misaligned = addr_i[0];
         2'b10:   misaligned = |addr_i[1:0];
         default: misaligned = 1'b0;
      endcase
      accept = (state_q == IDLE) & start & ~illegal & ~misaligned;

      be_d    = 4'b1111;
      wdata_d = store_data_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << {addr_i[1], 1'b0};
            wdata_d = {2{store_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Load formatting uses the latched size/sign and byte offset, not the live inputs.
   always_comb begin
      byte_sel = dmem_rdata_i[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (funct3_q)
         3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  fmt_data = {24'd0, byte_sel};
         3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  fmt_data = {16'd0, half_sel};
         default: fmt_data = dmem_rdata_i;
      endcase
   end

   always_comb begin
      limit   = (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
      timeout = limit & (((state_q == REQ) & ~dmem_gnt_i) | ((state_q == RESP) & ~dmem_rvalid_i));
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = REQ;
         REQ: begin
            if (dmem_gnt_i) state_d = we_q ? DONE : RESP;
            else if (limit) state_d = DONE;
         end
         RESP: if (dmem_rvalid_i || limit) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Any state change restarts the progress counter, which covers entry to REQ and RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else if (state_d != state_q)
         cnt_q <= '0;
      else if ((state_q == REQ) || (state_q == RESP))
         cnt_q <= cnt_q + 1'b1;
   end

   // NOTE: the latched access fields are reset too, so dmem_* never shows stale X after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         off_q    <= '0;
      end else if (accept) begin
         we_q     <= mem_write_i;
         be_q     <= be_d;
         addr_q   <= {addr_i[DATAWIDTH-1:2], 2'b00};
         wdata_q  <= wdata_d;
         funct3_q <= funct3_i;
         off_q    <= addr_i[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         load_data_q <= '0;
      else if ((state_q == RESP) && dmem_rvalid_i)
         load_data_q <= fmt_data;
      else if (timeout)
         load_data_q <= '0;
   end

   assign load_data_o = load_data_q;

   always_comb begin
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_be_o    = '0;
      dmem_wdata_o = '0;
      stall_o      = 1'b0;
      misalign_o   = 1'b0;
      bus_err_o    = 1'b0;
      case (state_q)
         IDLE: begin
            stall_o    = accept;
            bus_err_o  = start & illegal;
            misalign_o = start & ~illegal & misaligned;
         end
         REQ: begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = we_q;
            dmem_addr_o  = addr_q;
            dmem_be_o    = be_q;
            dmem_wdata_o = wdata_q;
            stall_o      = 1'b1;
            bus_err_o    = timeout;
         end
         RESP: begin
            stall_o   = 1'b1;
            bus_err_o = timeout;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed plan steps plus randomized accesses,
// every cycle compared against a byte-lane/arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] addr_i = '0, store_data_i = '0;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
   logic [31:0] dmem_rdata_i = '0;
   logic [31:0] load_data_o;
   logic        stall_o, misalign_o, bus_err_o;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_ld = '0;

   mem_stage_lsu #(.DATAWIDTH(32), .TIMEOUT_CYCLES(T), .CNTW(5)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
      .store_data_i(store_data_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .load_data_o(load_data_o), .stall_o(stall_o), .misalign_o(misalign_o),
      .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Access bytes: 1, 2 or 4, taken from the size field of funct3.
   function automatic int op_bytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   // 0 = legal and aligned, 1 = illegal op, 2 = misaligned.
   function automatic int classify(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
      if (rd && wr) return 1;
      if (rd && (f3 inside {3'b011, 3'b110, 3'b111})) return 1;
      if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1;
      if ((int'(a[1:0]) % op_bytes(f3)) != 0) return 2;
      return 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      int m;
      m = ((1 << op_bytes(f3)) - 1) << int'(a[1:0]);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % op_bytes(f3)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
      longint unsigned v;
      int bits;
      bits = 8 * op_bytes(f3);
      v = {32'd0, word} >> (8 * int'(a[1:0]));
      if (bits < 32) begin
         v = v & ((64'd1 << bits) - 1);
         if (!f3[2] && v[bits-1]) v = v - (64'd1 << bits);
      end
      return v[31:0];
   endfunction

   // One EX/MEM instruction. gnt_at/rv_at: 1-based REQ/RESP cycle of gnt/rvalid, 0 = never.
   // rst_at: RESP cycle in which reset is pulled, 0 = none.
   task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                             input int gnt_at, input int rv_at, input int rst_at);
      int cls, k, stalls, exp_stalls;
      bit got, req_to;
      cls = classify(rd, wr, f3, a);
      @(negedge clk);
      valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
      addr_i = a; store_data_i = sd; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      #1;
      check("idle_stall", stall_o, cls == 0);
      check("idle_bus_err", bus_err_o, cls == 1);
      check("idle_misalign", misalign_o, cls == 2);
      check("idle_req", dmem_req_o, 0);
      if (cls != 0) begin
         @(negedge clk);
         valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
         #1;
         check("reject_stall", stall_o, 0);
         check("reject_req", dmem_req_o, 0);
         check("reject_ld", load_data_o, exp_ld);
         return;
      end
      req_to = !(gnt_at >= 1 && gnt_at <= T);
      exp_stalls = 1 + (req_to ? T : gnt_at);
      if (rd && !req_to) exp_stalls += (rv_at >= 1 && rv_at <= T) ? rv_at : T;
      stalls = 1;

      got = 1'b0; k = 0;
      while (!got && k < T) begin
         k++;
         @(negedge clk);
         addr_i = $urandom; store_data_i = $urandom; funct3_i = 3'($urandom);
         dmem_gnt_i = (k == gnt_at);
         dmem_rvalid_i = 1'($urandom_range(0, 1));
         dmem_rdata_i = $urandom;
         #1;
         check("req_req", dmem_req_o, 1);
         check("req_we", dmem_we_o, wr);
         check("req_addr", dmem_addr_o, {a[31:2], 2'b00});
         check("req_be", dmem_be_o, model_be(f3, a));
         check("req_wdata", dmem_wdata_o, model_wdata(f3, sd));
         check("req_bus_err", bus_err_o, (k == T) && (k != gnt_at));
         check("req_ld_hold", load_data_o, exp_ld);
         stalls += stall_o;
         got = (k == gnt_at);
      end
      if (req_to) exp_ld = '0;

      if (rd && !req_to) begin
         got = 1'b0; k = 0;
         while (!got && k < T) begin
            k++;
            @(negedge clk);
            dmem_gnt_i = 1'($urandom_range(0, 1));
            dmem_rvalid_i = (k == rv_at);
            dmem_rdata_i = (k == rv_at) ? rdata : $urandom;
            if (k == rst_at) begin
               dmem_rvalid_i = 1'b0;
               #2;
               rst = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0; dmem_gnt_i = 1'b0;
               exp_ld = '0;
               #1;
               check("rst_req", dmem_req_o, 0);
               check("rst_stall", stall_o, 0);
               check("rst_ld", load_data_o, 0);
               check("rst_be", dmem_be_o, 0);
               check("rst_bus_err", bus_err_o, 0);
               @(negedge clk);
               rst = 1'b1;
               return;
            end
            #1;
            check("resp_req", dmem_req_o, 0);
            check("resp_stall", stall_o, 1);
            check("resp_bus_err", bus_err_o, (k == T) && (k != rv_at));
            check("resp_ld_hold", load_data_o, exp_ld);
            stalls += stall_o;
            got = (k == rv_at);
         end
         exp_ld = got ? model_load(f3, a, rdata) : 32'd0;
      end

      @(negedge clk);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; funct3_i = 3'($urandom); addr_i = $urandom;
      #1;
      check("done_stall", stall_o, 0);
      check("done_req", dmem_req_o, 0);
      check("done_bus_err", bus_err_o, 0);
      check("done_misalign", misalign_o, 0);
      check("done_ld", load_data_o, exp_ld);
      check("stall_cycles", stalls, exp_stalls);

      @(negedge clk);
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      #1;
      check("idle_after_stall", stall_o, 0);
      check("idle_after_req", dmem_req_o, 0);
   endtask

   initial begin
      bit          rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          ga, ra;

      #3;
      check("rst_state_req", dmem_req_o, 0);
      check("rst_state_we", dmem_we_o, 0);
      check("rst_state_addr", dmem_addr_o, 0);
      check("rst_state_wdata", dmem_wdata_o, 0);
      check("rst_state_ld", load_data_o, 0);
      check("rst_state_flags", {stall_o, misalign_o, bus_err_o}, 0);
      @(negedge clk);
      rst = 1'b1;

      run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 0, 0);
      run_access(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 1, 1, 0);
      check("lb_value", load_data_o, 32'hFFFFFF80);
      run_access(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 1, 1, 0);
      check("lbu_value", load_data_o, 32'h00000080);
      run_access(1, 0, 3'b101, 32'h102, 0, 32'h80123456, 1, 1, 0);
      check("lhu_value", load_data_o, 32'h00008012);
      run_access(0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 1, 0, 0);
      run_access(1, 0, 3'b001, 32'h101, 0, 0, 1, 1, 0);
      run_access(1, 0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 3, 2, 0);
      check("lw_value", load_data_o, 32'hCAFEF00D);
      run_access(0, 1, 3'b010, 32'h300, 32'h12345678, 0, 0, 0, 0);
      run_access(1, 0, 3'b011, 32'h400, 0, 0, 1, 1, 0);
      run_access(1, 1, 3'b010, 32'h400, 0, 0, 1, 1, 0);
      run_access(0, 1, 3'b001, 32'h502, 32'h0000BEEF, T, 0, 0, 0);
      run_access(1, 0, 3'b010, 32'h600, 0, 32'h11112222, 1, 0, 0);
      check("resp_timeout_ld", load_data_o, 0);
      run_access(1, 0, 3'b001, 32'h702, 0, 32'hA5A5F00F, 2, T, 0);
      check("rv_at_limit_ld", load_data_o, 32'hFFFFA5A5);
      run_access(1, 0, 3'b010, 32'h800, 0, 32'h0, 1, 0, 2);
      run_access(1, 0, 3'b010, 32'h804, 0, 32'h76543210, 1, 1, 0);
      check("post_rst_lw", load_data_o, 32'h76543210);

      for (int i = 0; i < 80; i++) begin
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 9) == 0) ? 1'b1 : !rd;
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
         else if (wr) f3 = 3'($urandom_range(0, 2));
         else f3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2));
         a = 32'h1000 + 32'($urandom_range(0, 255));
         ga = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4);
         ra = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4);
         run_access(rd, wr, f3, a, $urandom, $urandom, ga, ra, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
